// File: rtl/frog_game_pkg.sv
// Shared frog game definitions: state codes, bus widths and round defaults.
// Used by the round sequencer, frog control and display logic.
package frog_game_pkg;

  localparam int DATAWIDTH_ESTADO = 3;
  localparam int DATAWIDTH_VIDAS  = 3;
  localparam int DATAWIDTH_NIVEL  = 3;
  localparam int VIDAS_INI        = 3;
  localparam int RANAS_NIVEL      = 5;

  typedef enum logic [DATAWIDTH_ESTADO-1:0] {
    IDLE    = 3'd0,
    INICIO  = 3'd1,
    JUEGO   = 3'd2,
    MUERTE  = 3'd3,
    LLEGADA = 3'd4,
    NIVEL   = 3'd5,
    FIN     = 3'd6
  } state_t;

  function automatic logic is_pause(input state_t s);
    return (s == MUERTE) || (s == LLEGADA) || (s == NIVEL);
  endfunction

endpackage

// File: rtl/sc_tickdelay.sv
// Pause timer: counts frame ticks while enabled and flags the DELAY_TICKS-th one.
// done is combinational so the owner can leave its pause state on that same edge.
module sc_tickdelay #(
  parameter int DELAY_TICKS = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic done
);

  localparam int CW = $clog2(DELAY_TICKS + 1);

  logic [CW-1:0] count;

  assign done = enable && tick && (count == CW'(DELAY_TICKS - 1));

  // clear outranks tick so a tick landing on a state change never carries over
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && tick) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/frog_round_sequencer.sv
// Game-round sequencer: starts rounds, requests respawns, times death/arrival/level
// pauses on frame ticks and keeps lives, frogs-home and level counters.
module frog_round_sequencer #(
  parameter int DATAWIDTH_ESTADO = frog_game_pkg::DATAWIDTH_ESTADO,
  parameter int DATAWIDTH_VIDAS  = frog_game_pkg::DATAWIDTH_VIDAS,
  parameter int DATAWIDTH_NIVEL  = frog_game_pkg::DATAWIDTH_NIVEL,
  parameter int VIDAS_INI        = frog_game_pkg::VIDAS_INI,
  parameter int RANAS_NIVEL      = frog_game_pkg::RANAS_NIVEL,
  parameter int NIVEL_MAX        = 7,
  parameter int DELAY_TICKS      = 30
) (
  input  logic                        RS_CLOCK_50,
  input  logic                        RS_RESET,
  input  logic                        RS_START_IN,
  input  logic                        RS_TICK_IN,
  input  logic                        RS_PERDIO_IN,
  input  logic                        RS_GANO_IN,
  output logic [DATAWIDTH_ESTADO-1:0] RS_ESTADO_OUT,
  output logic                        RS_RANA_INI_OUT,
  output logic [DATAWIDTH_VIDAS-1:0]  RS_VIDAS_OUT,
  output logic [DATAWIDTH_NIVEL-1:0]  RS_NIVEL_OUT,
  output logic [2:0]                  RS_RANAS_OUT,
  output logic                        RS_FIN_OUT
);

  import frog_game_pkg::*;

  state_t                     state;
  state_t                     state_next;
  logic [DATAWIDTH_VIDAS-1:0] vidas;
  logic [DATAWIDTH_NIVEL-1:0] nivel;
  logic [2:0]                 ranas;
  logic                       tick_enable;
  logic                       tick_clear;
  logic                       tick_done;

  sc_tickdelay #(
    .DELAY_TICKS(DELAY_TICKS)
  ) u_tickdelay (
    .clk   (RS_CLOCK_50),
    .reset (RS_RESET),
    .clear (tick_clear),
    .enable(tick_enable),
    .tick  (RS_TICK_IN),
    .done  (tick_done)
  );

  always_ff @(posedge RS_CLOCK_50) begin
    if (RS_RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (RS_START_IN) state_next = INICIO;
      INICIO:  state_next = JUEGO;
      JUEGO: begin
        if (RS_PERDIO_IN) begin
          state_next = MUERTE;
        end else if (RS_GANO_IN) begin
          state_next = LLEGADA;
        end
      end
      // vidas was already decremented on entry, so zero here means the last life is gone
      MUERTE:  if (tick_done) state_next = (vidas == '0) ? FIN : INICIO;
      LLEGADA: if (tick_done) state_next = (ranas == 3'(RANAS_NIVEL)) ? NIVEL : INICIO;
      NIVEL:   if (tick_done) state_next = INICIO;
      FIN:     if (RS_START_IN) state_next = INICIO;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    RS_RANA_INI_OUT = 1'b0;
    RS_FIN_OUT      = 1'b0;
    tick_enable     = is_pause(state);
    case (state)
      INICIO:  RS_RANA_INI_OUT = 1'b1;
      FIN:     RS_FIN_OUT      = 1'b1;
      default: ;
    endcase
  end

  assign tick_clear = (state_next != state);

  // Round bookkeeping follows the transition that the FSM takes on the same edge
  always_ff @(posedge RS_CLOCK_50) begin
    if (RS_RESET) begin
      vidas <= DATAWIDTH_VIDAS'(VIDAS_INI);
      nivel <= '0;
      ranas <= '0;
    end else begin
      case (state)
        JUEGO: begin
          if (RS_PERDIO_IN) begin
            vidas <= vidas - DATAWIDTH_VIDAS'(1);
          end else if (RS_GANO_IN) begin
            ranas <= ranas + 3'd1;
          end
        end
        NIVEL: begin
          if (tick_done) begin
            ranas <= '0;
            if (nivel < DATAWIDTH_NIVEL'(NIVEL_MAX)) begin
              nivel <= nivel + DATAWIDTH_NIVEL'(1);
            end
          end
        end
        FIN: begin
          if (RS_START_IN) begin
            vidas <= DATAWIDTH_VIDAS'(VIDAS_INI);
            nivel <= '0;
            ranas <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign RS_ESTADO_OUT = DATAWIDTH_ESTADO'(state);
  assign RS_VIDAS_OUT  = vidas;
  assign RS_NIVEL_OUT  = nivel;
  assign RS_RANAS_OUT  = ranas;

endmodule

// File: tb/tb_frog_round_sequencer.sv
// Bench for frog_round_sequencer: directed round scenarios plus random play,
// all checked against a rule-level game model kept here.
module tb_frog_round_sequencer;

  import frog_game_pkg::*;

  localparam int DT   = 2;
  localparam int VI   = 3;
  localparam int RN   = 2;
  localparam int NMAX = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic       perdio = 1'b0;
  logic       gano = 1'b0;
  logic [2:0] estado;
  logic       rana_ini;
  logic [2:0] vidas;
  logic [2:0] nivel;
  logic [2:0] ranas;
  logic       fin;

  int checks = 0;
  int errors = 0;

  int m_state, m_vidas, m_nivel, m_ranas, m_ticks;

  always #10 clk = ~clk;

  frog_round_sequencer #(
    .DATAWIDTH_ESTADO(3),
    .DATAWIDTH_VIDAS (3),
    .DATAWIDTH_NIVEL (3),
    .VIDAS_INI       (VI),
    .RANAS_NIVEL     (RN),
    .NIVEL_MAX       (NMAX),
    .DELAY_TICKS     (DT)
  ) dut (
    .RS_CLOCK_50    (clk),
    .RS_RESET       (reset),
    .RS_START_IN    (start),
    .RS_TICK_IN     (tick),
    .RS_PERDIO_IN   (perdio),
    .RS_GANO_IN     (gano),
    .RS_ESTADO_OUT  (estado),
    .RS_RANA_INI_OUT(rana_ini),
    .RS_VIDAS_OUT   (vidas),
    .RS_NIVEL_OUT   (nivel),
    .RS_RANAS_OUT   (ranas),
    .RS_FIN_OUT     (fin)
  );

  // Game rules: 0 idle, 1 respawn, 2 play, 3 death pause, 4 arrival pause, 5 level pause, 6 game over
  task automatic model_step(input bit r, input bit s, input bit t, input bit p, input bit g);
    int  ns;
    bit  done;
    if (r) begin
      m_state = 0; m_vidas = VI; m_nivel = 0; m_ranas = 0; m_ticks = 0;
      return;
    end
    ns   = m_state;
    done = 1'b0;
    if ((m_state == 3 || m_state == 4 || m_state == 5) && t) begin
      m_ticks = m_ticks + 1;
      done = (m_ticks == DT);
    end
    case (m_state)
      0: if (s) ns = 1;
      1: ns = 2;
      2: begin
        if (p) begin ns = 3; m_vidas = m_vidas - 1; end
        else if (g) begin ns = 4; m_ranas = m_ranas + 1; end
      end
      3: if (done) ns = (m_vidas == 0) ? 6 : 1;
      4: if (done) ns = (m_ranas == RN) ? 5 : 1;
      5: if (done) begin
        ns = 1; m_ranas = 0;
        if (m_nivel < NMAX) m_nivel = m_nivel + 1;
      end
      6: if (s) begin ns = 1; m_vidas = VI; m_nivel = 0; m_ranas = 0; end
      default: ns = 0;
    endcase
    if (ns != m_state) m_ticks = 0;
    m_state = ns;
  endtask

  task automatic step_cycle(input bit s, input bit t, input bit p, input bit g);
    start = s; tick = t; perdio = p; gano = g;
    @(posedge clk);
    model_step(reset, s, t, p, g);
    #1;
    start = 1'b0; tick = 1'b0; perdio = 1'b0; gano = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step_cycle(1, 1, 1, 1);
    step_cycle(0, 0, 0, 0);
    reset = 1'b0;
    checks++; if (estado !== 3'd0) begin errors++; $display("[TB] FAIL reset_estado: got %0d expected 0", estado); end
    checks++; if (vidas !== 3'd3) begin errors++; $display("[TB] FAIL reset_vidas: got %0d expected 3", vidas); end
    checks++; if (nivel !== 3'd0 || ranas !== 3'd0) begin errors++; $display("[TB] FAIL reset_nivel_ranas: got %0d/%0d expected 0/0", nivel, ranas); end
    checks++; if (rana_ini !== 1'b0 || fin !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got %0b/%0b expected 0/0", rana_ini, fin); end
  endtask

  task automatic test_start;
    step_cycle(1, 0, 0, 0);
    checks++; if (estado !== 3'd1 || rana_ini !== 1'b1) begin errors++; $display("[TB] FAIL start_inicio: got estado %0d rana_ini %0b expected 1/1", estado, rana_ini); end
    step_cycle(0, 0, 0, 0);
    checks++; if (estado !== 3'd2 || rana_ini !== 1'b0) begin errors++; $display("[TB] FAIL start_juego: got estado %0d rana_ini %0b expected 2/0", estado, rana_ini); end
    checks++; if (vidas !== 3'd3 || nivel !== 3'd0 || ranas !== 3'd0) begin errors++; $display("[TB] FAIL start_counters: got %0d/%0d/%0d expected 3/0/0", vidas, nivel, ranas); end
  endtask

  task automatic test_death;
    logic [2:0] exp_vidas;
    for (int i = 0; i < 3; i++) begin
      exp_vidas = 3'(2 - i);
      step_cycle(0, 0, 1, 0);
      checks++; if (estado !== 3'd3 || vidas !== exp_vidas) begin errors++; $display("[TB] FAIL death_enter: got estado %0d vidas %0d expected 3/%0d", estado, vidas, exp_vidas); end
      step_cycle(0, 1, 0, 0);
      checks++; if (estado !== 3'd3) begin errors++; $display("[TB] FAIL death_pause: got %0d expected 3", estado); end
      step_cycle(0, 1, 0, 0);
      if (i < 2) begin
        checks++; if (estado !== 3'd1 || rana_ini !== 1'b1) begin errors++; $display("[TB] FAIL death_respawn: got estado %0d rana_ini %0b expected 1/1", estado, rana_ini); end
        step_cycle(0, 0, 0, 0);
        checks++; if (estado !== 3'd2) begin errors++; $display("[TB] FAIL death_resume: got %0d expected 2", estado); end
      end else begin
        checks++; if (estado !== 3'd6 || fin !== 1'b1 || vidas !== 3'd0) begin errors++; $display("[TB] FAIL game_over: got estado %0d fin %0b vidas %0d expected 6/1/0", estado, fin, vidas); end
      end
    end
    step_cycle(0, 1, 1, 1);
    checks++; if (estado !== 3'd6) begin errors++; $display("[TB] FAIL fin_ignores: got %0d expected 6", estado); end
    step_cycle(1, 0, 0, 0);
    checks++; if (estado !== 3'd1 || vidas !== 3'd3 || fin !== 1'b0) begin errors++; $display("[TB] FAIL restart: got estado %0d vidas %0d fin %0b expected 1/3/0", estado, vidas, fin); end
    step_cycle(0, 0, 0, 0);
  endtask

  task automatic test_levels;
    logic [2:0] exp_nivel;
    for (int lvl = 0; lvl < 8; lvl++) begin
      for (int k = 0; k < RN; k++) begin
        step_cycle(0, 0, 0, 1);
        checks++; if (estado !== 3'd4 || ranas !== 3'(k + 1)) begin errors++; $display("[TB] FAIL arrive: got estado %0d ranas %0d expected 4/%0d", estado, ranas, k + 1); end
        step_cycle(0, 1, 0, 0);
        step_cycle(0, 1, 0, 0);
        if (k < RN - 1) begin
          checks++; if (estado !== 3'd1) begin errors++; $display("[TB] FAIL arrive_respawn: got %0d expected 1", estado); end
          step_cycle(0, 0, 0, 0);
        end else begin
          checks++; if (estado !== 3'd5) begin errors++; $display("[TB] FAIL level_enter: got %0d expected 5", estado); end
        end
      end
      exp_nivel = (lvl >= NMAX - 1) ? 3'(NMAX) : 3'(lvl + 1);
      step_cycle(0, 1, 0, 0);
      step_cycle(0, 1, 0, 0);
      checks++; if (estado !== 3'd1 || nivel !== exp_nivel || ranas !== 3'd0) begin errors++; $display("[TB] FAIL level_done: got estado %0d nivel %0d ranas %0d expected 1/%0d/0", estado, nivel, ranas, exp_nivel); end
      step_cycle(0, 0, 0, 0);
    end
  endtask

  task automatic test_precedence;
    step_cycle(0, 1, 1, 1);
    checks++; if (estado !== 3'd3 || vidas !== 3'd2 || ranas !== 3'd0) begin errors++; $display("[TB] FAIL precedence: got estado %0d vidas %0d ranas %0d expected 3/2/0", estado, vidas, ranas); end
    step_cycle(0, 1, 0, 0);
    checks++; if (estado !== 3'd3) begin errors++; $display("[TB] FAIL entry_tick_counted: got %0d expected 3", estado); end
    step_cycle(0, 1, 0, 0);
    checks++; if (estado !== 3'd1) begin errors++; $display("[TB] FAIL entry_tick_exit: got %0d expected 1", estado); end
    step_cycle(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_pause;
    step_cycle(0, 0, 1, 0);
    step_cycle(0, 1, 0, 0);
    reset = 1'b1;
    step_cycle(0, 1, 0, 0);
    reset = 1'b0;
    checks++; if (estado !== 3'd0 || vidas !== 3'd3 || nivel !== 3'd0) begin errors++; $display("[TB] FAIL reset_pause: got estado %0d vidas %0d nivel %0d expected 0/3/0", estado, vidas, nivel); end
    step_cycle(0, 1, 1, 1);
    checks++; if (estado !== 3'd0 || vidas !== 3'd3 || ranas !== 3'd0) begin errors++; $display("[TB] FAIL idle_ignores: got estado %0d vidas %0d ranas %0d expected 0/3/0", estado, vidas, ranas); end
    step_cycle(1, 0, 0, 0);
    step_cycle(0, 0, 0, 0);
    step_cycle(0, 0, 1, 0);
    step_cycle(0, 1, 0, 0);
    checks++; if (estado !== 3'd3) begin errors++; $display("[TB] FAIL counter_cleared: got %0d expected 3", estado); end
    step_cycle(0, 1, 0, 0);
    checks++; if (estado !== 3'd1) begin errors++; $display("[TB] FAIL counter_exit: got %0d expected 1", estado); end
    step_cycle(0, 0, 0, 0);
  endtask

  task automatic test_illegal_state;
    step_cycle(1, 0, 0, 0);
    checks++; if (estado !== 3'd2) begin errors++; $display("[TB] FAIL start_in_juego: got %0d expected 2", estado); end
    force dut.state_next = state_t'(3'd7);
    @(posedge clk);
    #1;
    release dut.state_next;
    m_state = 7;
    m_ticks = 0;
    start = 1'b1;
    #1;
    start = 1'b0;
    checks++; if (estado !== 3'd7) begin errors++; $display("[TB] FAIL illegal_loaded: got %0d expected 7", estado); end
    step_cycle(0, 0, 0, 0);
    checks++; if (estado !== 3'd0) begin errors++; $display("[TB] FAIL illegal_recover: got %0d expected 0", estado); end
  endtask

  task automatic test_random;
    bit s, t, p, g;
    logic [2:0] exp_state;
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 149) == 0);
      s = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 1) == 1);
      p = ($urandom_range(0, 6) == 0);
      g = ($urandom_range(0, 3) == 0);
      step_cycle(s, t, p, g);
      reset = 1'b0;
      exp_state = 3'(m_state);
      checks++; if (estado !== exp_state) begin errors++; $display("[TB] FAIL rnd_estado cycle %0d: got %0d expected %0d", n, estado, exp_state); end
      checks++; if (vidas !== 3'(m_vidas) || nivel !== 3'(m_nivel) || ranas !== 3'(m_ranas)) begin errors++; $display("[TB] FAIL rnd_counters cycle %0d: got %0d/%0d/%0d expected %0d/%0d/%0d", n, vidas, nivel, ranas, m_vidas, m_nivel, m_ranas); end
      checks++; if (rana_ini !== (m_state == 1) || fin !== (m_state == 6)) begin errors++; $display("[TB] FAIL rnd_flags cycle %0d: got %0b/%0b expected %0b/%0b", n, rana_ini, fin, m_state == 1, m_state == 6); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_start;
    test_death;
    test_levels;
    test_precedence;
    test_reset_mid_pause;
    test_illegal_state;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
